// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the pixel RAM between VGA scan-out (priority), a buffered pixel writer and a clear-screen sweep
module vram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_PIX      = 640,
    parameter int V_PIX      = 480
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic        vga_rdn,
    input  logic [8:0]  vga_row,
    input  logic [9:0]  vga_col,
    output logic [11:0] vga_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [8:0]  wr_row,
    input  logic [9:0]  wr_col,
    input  logic [11:0] wr_data,
    input  logic        clr_start,
    input  logic [11:0] clr_color,
    output logic        busy,
    output logic        clr_done,
    output logic [18:0] ram_addr,
    output logic        ram_we,
    output logic [11:0] ram_wdata,
    input  logic [11:0] ram_rdata
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t        state_q;
    logic [30:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [8:0]    cr_q;
    logic [9:0]    cc_q;
    logic [11:0]   clr_color_q;
    logic          clr_done_q;
    logic [30:0]   head;
    logic          push, pop, in_rng, clr_wr, last;

    assign head     = mem_q[rp_q];
    assign wr_ready = (cnt_q != (AW+1)'(FIFO_DEPTH)) && (state_q == IDLE);
    assign push     = wr_valid && wr_ready;
    assign pop      = vga_rdn && (cnt_q != '0) && (state_q != CLEAR);
    assign in_rng   = (head[30:22] < 9'(V_PIX)) && (head[21:12] < 10'(H_PIX));
    assign clr_wr   = vga_rdn && (state_q == CLEAR);
    assign last     = clr_wr && (cr_q == 9'(V_PIX - 1)) && (cc_q == 10'(H_PIX - 1));
    assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    assign busy     = state_q != IDLE;
    assign clr_done = clr_done_q;
    assign vga_data = ram_rdata;

    // Scan-out owns the port whenever it reads; otherwise the sweep or the FIFO head drives it.
    always_comb begin
        ram_we    = clr_wr || (pop && in_rng);
        ram_addr  = !vga_rdn ? {vga_row, vga_col} : clr_wr ? {cr_q, cc_q} : pop ? head[30:12] : '0;
        ram_wdata = clr_wr ? clr_color_q : pop ? head[11:0] : '0;
    end

    // FIFO storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge vga_clk) begin
        if (push) mem_q[wp_q] <= {wr_row, wr_col, wr_data};
    end

    // FIFO pointers, controller state and the clear-screen sweep counters.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            cr_q        <= '0;
            cc_q        <= '0;
            clr_color_q <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q      <= cnt_d;
            clr_done_q <= last;
            case (state_q)
                IDLE: if (clr_start) begin
                    clr_color_q <= clr_color;
                    state_q     <= (cnt_q == '0) ? CLEAR : DRAIN;
                end
                DRAIN: if (cnt_d == '0) state_q <= CLEAR;
                CLEAR: if (last) begin
                    state_q <= IDLE;
                    cr_q    <= '0;
                    cc_q    <= '0;
                end else if (clr_wr) begin
                    cc_q <= (cc_q == 10'(H_PIX - 1)) ? '0 : cc_q + 1'b1;
                    if (cc_q == 10'(H_PIX - 1)) cr_q <= cr_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
